reaction_stats: RTL and testbench

Statistics stage between the reaction-time FSM and the binary-to-BCD converter. It captures each finished reaction time and keeps a sliding window of the most recent trials. It produces one 14-bit value for the display path: last time, best time, windowed average, or trial count. The average comes from an iterative restoring divider, so the block has a busy phase after every new sample.

---
 rtl/reaction_stats_if.sv | 27 ++
 rtl/reaction_stats.sv | 140 ++++++++++++++
 tb/tb_reaction_stats.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/reaction_stats_if.sv
// Handshake and display bundle between the reaction-time FSM, the stats stage and binToBCD.
// The tb drives through master; the stats block sits on slave.
interface reaction_stats_if #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              i_select;
    logic              i_clear;
    logic [DATA_W-1:0] o_data;
    logic [1:0]        o_mode;
    logic [CNT_W-1:0]  o_count;
    logic              o_busy;

    modport master (
        output i_valid, i_data, i_select, i_clear,
        input  o_data, o_mode, o_count, o_busy
    );

    modport slave (
        input  i_valid, i_data, i_select, i_clear,
        output o_data, o_mode, o_count, o_busy
    );
endinterface

// File: rtl/reaction_stats.sv
// Reaction-time statistics: sliding window of recent trials, all-time best,
// and a windowed average from a bit-serial restoring divider.
module reaction_stats #(
    parameter int DATA_W  = 14,
    parameter int DEPTH   = 8,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    reaction_stats_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = DATA_W + PTR_W;
    localparam int IT_W  = $clog2(SUM_W);

    localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_VAL);
    localparam logic [0:0]        IDLE  = 1'b0;
    localparam logic [0:0]        DIV   = 1'b1;

    logic [DATA_W-1:0] hist [DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  count;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] last, best, avg;

    logic [0:0]        state;
    logic [IT_W-1:0]   iter;
    logic [SUM_W-1:0]  quo, rem;
    logic [CNT_W-1:0]  dvsr;
    logic [1:0]        mode;

    logic [DATA_W-1:0] stored;
    logic              full;
    logic [SUM_W-1:0]  sum_next;
    logic [CNT_W-1:0]  cnt_next;
    logic [SUM_W-1:0]  shifted, rem_step, quo_step;
    logic [SUM_W:0]    diff;
    logic              q_bit;

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        stored   = (bus.i_data > MAX_V) ? MAX_V : bus.i_data;
        full     = (count == CNT_W'(DEPTH));
        sum_next = sum + SUM_W'(stored);
        cnt_next = count + CNT_W'(1);
        if (full) begin
            sum_next = sum - SUM_W'(hist[ptr]) + SUM_W'(stored);
            cnt_next = count;
        end

        // One restoring step: remainder stays below the divisor, so the shift never overflows.
        shifted  = {rem[SUM_W-2:0], quo[SUM_W-1]};
        diff     = {1'b0, shifted} - (SUM_W+1)'(dvsr);
        q_bit    = ~diff[SUM_W];
        rem_step = q_bit ? diff[SUM_W-1:0] : shifted;
        quo_step = {quo[SUM_W-2:0], q_bit};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    // NOTE: the history buffer is reset like any other register because clear and reset must both read back as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            ptr   <= '0;
            count <= '0;
            sum   <= '0;
            last  <= '0;
            best  <= '0;
        end else if (bus.i_clear) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            ptr   <= '0;
            count <= '0;
            sum   <= '0;
            last  <= '0;
            best  <= '0;
        end else if (bus.i_valid) begin
            hist[ptr] <= stored;
            ptr       <= ptr + PTR_W'(1);
            count     <= cnt_next;
            sum       <= sum_next;
            last      <= stored;
            // Best spans all trials since clear; an empty history takes the first sample outright.
            if (count == '0 || stored < best) best <= stored;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            iter  <= '0;
            quo   <= '0;
            rem   <= '0;
            dvsr  <= '0;
            avg   <= '0;
        end else if (bus.i_clear) begin
            state <= IDLE;
            iter  <= '0;
            quo   <= '0;
            rem   <= '0;
            dvsr  <= '0;
            avg   <= '0;
        end else if (bus.i_valid) begin
            // A new sample (re)starts the divide from the updated totals.
            state <= DIV;
            iter  <= IT_W'(SUM_W - 1);
            quo   <= sum_next;
            rem   <= '0;
            dvsr  <= cnt_next;
        end else if (state == DIV) begin
            quo <= quo_step;
            rem <= rem_step;
            if (iter == '0) begin
                state <= IDLE;
                avg   <= quo_step[DATA_W-1:0];
            end else begin
                iter <= iter - IT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode       <= 2'd0;
            bus.o_data <= '0;
        end else begin
            mode <= mode + 2'(bus.i_select);
            unique case (mode)
                2'd0:    bus.o_data <= last;
                2'd1:    bus.o_data <= best;
                2'd2:    bus.o_data <= avg;
                default: bus.o_data <= DATA_W'(count);
            endcase
        end
    end

    assign bus.o_mode  = mode;
    assign bus.o_count = count;
    assign bus.o_busy  = (state == DIV);
endmodule

// File: tb/tb_reaction_stats.sv
// Directed bench for reaction_stats: hand-computed window, best, average and timing vectors.
module tb_reaction_stats;
    localparam int DATA_W = 14;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    reaction_stats_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    reaction_stats #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_VAL(9999)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic sample(input int d);
        bus.i_data  = d[DATA_W-1:0];
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic clear_hist();
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
    endtask

    task automatic select_pulse();
        bus.i_select = 1'b1;
        @(negedge clk);
        bus.i_select = 1'b0;
    endtask

    task automatic goto_mode(input int m);
        for (int i = 0; i < 4 && int'(bus.o_mode) != m; i++) select_pulse();
        @(negedge clk);
    endtask

    task automatic expect_val(input string tag, input int m, input int exp);
        goto_mode(m);
        check({tag, "_mode"}, bus.o_mode, m);
        check(tag, bus.o_data, exp);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100 && bus.o_busy; n++) @(negedge clk);
        check("idle", bus.o_busy, 0);
        @(negedge clk);
    endtask

    // Counts falling edges with o_busy high; also flags any AVG-mode change while busy.
    task automatic count_busy(output int n, output int changed);
        n = 0;
        changed = 0;
        while (bus.o_busy && n < 100) begin
            if (bus.o_data != '0) changed = 1;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int changed;
        bus.i_valid  = 1'b0;
        bus.i_data   = '0;
        bus.i_select = 1'b0;
        bus.i_clear  = 1'b0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_data",  bus.o_data,  0);
        check("rst_mode",  bus.o_mode,  0);
        check("rst_count", bus.o_count, 0);
        check("rst_busy",  bus.o_busy,  0);
        rst = 1'b0;
        @(negedge clk);

        for (int m = 1; m <= 3; m++) begin
            select_pulse();
            check("sel_mode", bus.o_mode, m);
            @(negedge clk);
            check("empty_data", bus.o_data, 0);
        end
        select_pulse();
        check("sel_wrap", bus.o_mode, 0);

        // 300, 250, 400: avg 950/3 = 316
        sample(300);
        @(negedge clk);
        sample(250);
        @(negedge clk);
        sample(400);
        count_busy(n, changed);
        check("busy_len", n, 17);
        @(negedge clk);
        expect_val("last3", 0, 400);
        expect_val("best3", 1, 250);
        expect_val("avg3",  2, 316);
        expect_val("cnt3",  3, 3);
        check("o_count3", bus.o_count, 3);

        // Window wrap: 300..1000 remain, 5200/8 = 650
        clear_hist();
        for (int i = 1; i <= 10; i++) sample(i * 100);
        wait_idle();
        check("wrap_count", bus.o_count, 8);
        expect_val("wrap_last", 0, 1000);
        expect_val("wrap_best", 1, 100);
        expect_val("wrap_avg",  2, 650);

        // Clamp: 12000 -> 9999; (9999 + 1) / 2 = 5000
        clear_hist();
        sample(12000);
        expect_val("clamp_last", 0, 9999);
        sample(1);
        wait_idle();
        expect_val("clamp_best", 1, 1);
        expect_val("clamp_avg",  2, 5000);

        // Clear and valid together: clear wins, divide aborted, mode kept
        clear_hist();
        goto_mode(1);
        sample(10);
        sample(20);
        bus.i_clear = 1'b1;
        bus.i_data  = 14'd500;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
        bus.i_valid = 1'b0;
        check("coll_busy",  bus.o_busy,  0);
        check("coll_count", bus.o_count, 0);
        check("coll_mode",  bus.o_mode,  1);
        @(negedge clk);
        check("coll_best", bus.o_data, 0);
        repeat (25) @(negedge clk);
        expect_val("coll_avg",  2, 0);
        expect_val("coll_last", 0, 0);

        // Restart: 400, then 200 five cycles later; only 300 is ever loaded
        clear_hist();
        goto_mode(2);
        sample(400);
        repeat (4) @(negedge clk);
        check("restart_pre_busy", bus.o_busy, 1);
        check("restart_pre_avg",  bus.o_data, 0);
        sample(200);
        count_busy(n, changed);
        check("restart_len",     n, 17);
        check("restart_no_glit", changed, 0);
        check("restart_lag",     bus.o_data, 0);
        @(negedge clk);
        check("restart_avg", bus.o_data, 300);

        // Reset mid-divide
        clear_hist();
        sample(400);
        repeat (4) @(negedge clk);
        sample(200);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  bus.o_busy,  0);
        check("mid_rst_mode",  bus.o_mode,  0);
        check("mid_rst_count", bus.o_count, 0);
        check("mid_rst_data",  bus.o_data,  0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("post_rst_busy", bus.o_busy, 0);
        expect_val("post_rst_avg", 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
